xunit_sha256_compress: RTL

Versat functional unit that consumes the SHA-256 expanded message-schedule word stream, one W_t per cycle, and runs the 64 compression rounds. It holds the chaining hash H0..H7 across blocks and streams the updated digest words on out0 after each block. It is the consumer end of the message-schedule unit's out0 stream and is placed directly downstream of that unit in a Versat datapath.

---
 rtl/sha256_pkg.sv | 56 +++++
 rtl/xunit_sha256_round.sv | 43 ++++
 rtl/xunit_sha256_compress.sv | 116 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and round helper functions shared by the
// compression unit and its single-round datapath.
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ROUND,
        S_ACCUM,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/xunit_sha256_round.sv
// One combinational SHA-256 compression round: working variables in, next
// working variables out.
module xunit_sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] f,
    input  logic [31:0] g,
    input  logic [31:0] h,
    input  logic [31:0] w,
    input  logic [31:0] k,
    output logic [31:0] a_next,
    output logic [31:0] b_next,
    output logic [31:0] c_next,
    output logic [31:0] d_next,
    output logic [31:0] e_next,
    output logic [31:0] f_next,
    output logic [31:0] g_next,
    output logic [31:0] h_next
);

    logic [31:0] t1;
    logic [31:0] t2;

    // Round function; all additions wrap modulo 2^32.
    always_comb begin
        t1     = h + bsig1(e) + ch(e, f, g) + k + w;
        t2     = bsig0(a) + maj(a, b, c);
        a_next = t1 + t2;
        b_next = a;
        c_next = b;
        d_next = c;
        e_next = d + t1;
        f_next = e;
        g_next = f;
        h_next = g;
    end

endmodule

// File: rtl/xunit_sha256_compress.sv
// SHA-256 compression functional unit: consumes one W_t per cycle, runs 64
// rounds, accumulates into the chaining hash and streams H0..H7 on out0.
//
// state   | meaning
// S_IDLE  | after reset, waiting for run
// S_WAIT  | counting down delay until W_0 arrives
// S_ROUND | one compression round per active cycle, t = 0..63
// S_ACCUM | fold working variables into H0..H7
// S_OUT   | stream H[k] on out0, k = 0..7
// S_DONE  | block finished, out0 holds H7
module xunit_sha256_compress
    import sha256_pkg::*;
#(
    parameter int DELAY_W = 32,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               running,
    input  logic               run,
    output logic               done,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0,
    input  logic [DELAY_W-1:0] delay0,
    input  logic               init
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("xunit_sha256_compress: DATA_W must be 32");
    end

    state_t             state;
    logic [DELAY_W-1:0] delay;
    logic [5:0]         t;
    logic [2:0]         k;
    logic [31:0]        h_reg [8];
    logic [31:0]        wv    [8];
    logic [31:0]        nxt   [8];

    xunit_sha256_round u_round (
        .a      (wv[0]),
        .b      (wv[1]),
        .c      (wv[2]),
        .d      (wv[3]),
        .e      (wv[4]),
        .f      (wv[5]),
        .g      (wv[6]),
        .h      (wv[7]),
        .w      (in0),
        .k      (K[t]),
        .a_next (nxt[0]),
        .b_next (nxt[1]),
        .c_next (nxt[2]),
        .d_next (nxt[3]),
        .e_next (nxt[4]),
        .f_next (nxt[5]),
        .g_next (nxt[6]),
        .h_next (nxt[7])
    );

    // Sequencing FSM; done follows the state one cycle late so it rises the
    // cycle after the last digest word, but run clears it immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            delay <= '0;
            t     <= '0;
            k     <= '0;
            out0  <= '0;
            done  <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV[i];
                wv[i]    <= '0;
            end
        end else if (run) begin
            delay <= delay0;
            t     <= '0;
            k     <= '0;
            done  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (init) begin
                    h_reg[i] <= IV[i];
                    wv[i]    <= IV[i];
                end else begin
                    wv[i]    <= h_reg[i];
                end
            end
            state <= (delay0 == '0) ? S_ROUND : S_WAIT;
        end else if (running) begin
            done <= (state == S_IDLE) || (state == S_DONE);
            case (state)
                S_WAIT: begin
                    delay <= delay - 1'b1;
                    if (delay == {{(DELAY_W-1){1'b0}}, 1'b1}) state <= S_ROUND;
                end
                S_ROUND: begin
                    for (int i = 0; i < 8; i++) wv[i] <= nxt[i];
                    t <= t + 1'b1;
                    if (t == 6'd63) state <= S_ACCUM;
                end
                S_ACCUM: begin
                    for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wv[i];
                    k     <= '0;
                    state <= S_OUT;
                end
                S_OUT: begin
                    out0 <= h_reg[k];
                    k    <= k + 1'b1;
                    if (k == 3'd7) state <= S_DONE;
                end
                default: ;
            endcase
        end
    end

endmodule
